regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with a write-back scoreboard, forming the next-generation architectural register file for the pipelined core. It provides two combinational read ports, two posedge write-back ports with a defined conflict priority, and optional same-cycle write-to-read bypass. A per-register busy bit tracks in-flight producers so that decode can stall on RAW hazards without a separate hazard table. Register 0 reads as zero and is never busy.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 2)
- AW, $clog2(NREGS), address width; derived, not overridden
- BYPASS, 1, 1 = same-cycle write data and busy-clear forwarded to read ports; 0 = reads show registered state only

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- rs1_addr, rs2_addr  in  AW  read addresses
- rs1_data, rs2_data  out  XLEN  read data
- rs1_busy, rs2_busy  out  1  addressed register has a pending producer
- wr0_en, wr1_en  in  1  write-back enables
- wr0_addr, wr1_addr  in  AW  write-back destinations
- wr0_data, wr1_data  in  XLEN  write-back data
- issue_en  in  1  an instruction with destination issue_rd was issued this cycle
- issue_rd  in  AW  destination of the issued instruction
- flush  in  1  pipeline flush; clears all busy bits

## Operation
- Reset (async, immediate, including mid-operation): all NREGS entries = 0, all busy bits = 0; therefore rs*_data = 0 and rs*_busy = 0 while rst is high.
- Writes: on posedge, wrN_en with wrN_addr ≠ 0 stores wrN_data. Writes to address 0 are discarded.
- Dual write to the same address in one cycle: port 1 wins (younger instruction).
- Reads: combinational. Address 0 always returns 0 and busy 0, regardless of writes or issue.
- Bypass (BYPASS = 1): if a write enable targets the read address (≠ 0) this cycle, rs*_data returns that write data (port 1 over port 0) and rs*_busy returns 0. BYPASS = 0: registered contents and busy bits only.
- Scoreboard per register r ≠ 0, next-state priority, highest first:
  1. flush → busy[r] = 0
  2. issue_en && issue_rd == r → busy[r] = 1 (a new producer supersedes a completing one)
  3. wr0_en or wr1_en targeting r → busy[r] = 0
  4. otherwise hold
- issue_en with issue_rd == 0 has no effect. Issue does not affect the same-cycle read busy outputs; the bit is visible from the next cycle.
- Writes to a non-busy register are legal and update data normally (no error flag).

## Timing
- Read latency 0 cycles (combinational from address and, when BYPASS = 1, from write ports).
- Write latency 1 edge: data visible on a registered read the cycle after the write; with BYPASS = 1, the same cycle.
- Busy set latency 1 edge after issue; busy clear latency 1 edge after write-back (0 with bypass).
- No handshake: every enable is single-cycle and is consumed on the edge it is sampled.
- Writes on the rising edge only. The previous negedge-write scheme is replaced by explicit bypass.

## Structure
- Shared package `regfile_pkg`: default XLEN/NREGS constants and the register-index zero constant, for use by decode and hazard logic.
- One sub-module, `regfile_scoreboard`: the NREGS-bit busy vector, the priority logic, and two busy read ports with bypass mask. The data array stays in `regfile_mp`.
- Bypass muxing stays in the top level and is gated by a generate on BYPASS.

## Test plan
- Reset: write 0xDEADBEEF to x5, assert rst asynchronously mid-cycle → rs1_data(x5) = 0 immediately, all busy = 0.
- x0: wr0 x0 = 0x1234, issue_rd = 0 → rs1_data(x0) = 0, rs1_busy = 0 on every later cycle.
- Dual-write conflict: wr0 x7 = 0x11, wr1 x7 = 0x22 in the same cycle → x7 = 0x22 next cycle; with BYPASS = 1, the same-cycle read of x7 = 0x22.
- Bypass off vs on: write x3 = 0xA5A5 while reading x3 (old value 0) → BYPASS = 1 gives 0xA5A5 same cycle; BYPASS = 0 gives 0, then 0xA5A5 next cycle.
- Scoreboard: issue x9 → busy next cycle; issue x9 and write x9 in the same cycle → stays busy; a later write x9 → busy clears.
- Flush priority: busy set on x4 and x12, then flush with issue x4 in the same cycle → all busy = 0 next cycle. Repeat with NREGS = 16, XLEN = 64.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants for decode, hazard logic and the register file.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int REG_ZERO  = 0;

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file bus: two read ports, two write-back ports, issue and flush.
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int AW   = $clog2(NREGS_DEF)
);

   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            wr0_en;
   logic [AW-1:0]   wr0_addr;
   logic [XLEN-1:0] wr0_data;
   logic            wr1_en;
   logic [AW-1:0]   wr1_addr;
   logic [XLEN-1:0] wr1_data;
   logic            issue_en;
   logic [AW-1:0]   issue_rd;
   logic            flush;

   modport master (
      output rs1_addr, rs2_addr,
      output wr0_en, wr0_addr, wr0_data,
      output wr1_en, wr1_addr, wr1_data,
      output issue_en, issue_rd, flush,
      input  rs1_data, rs2_data, rs1_busy, rs2_busy
   );

   modport slave (
      input  rs1_addr, rs2_addr,
      input  wr0_en, wr0_addr, wr0_data,
      input  wr1_en, wr1_addr, wr1_data,
      input  issue_en, issue_rd, flush,
      output rs1_data, rs2_data, rs1_busy, rs2_busy
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits tracking in-flight producers, with two busy read ports.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS  = NREGS_DEF,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          issue_en,
   input  logic [AW-1:0] issue_rd,
   input  logic          wr0_en,
   input  logic [AW-1:0] wr0_addr,
   input  logic          wr1_en,
   input  logic [AW-1:0] wr1_addr,
   input  logic          flush,
   input  logic [AW-1:0] rs1_addr,
   input  logic [AW-1:0] rs2_addr,
   output logic          rs1_busy,
   output logic          rs2_busy
);

   localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   logic             rs1_hit;
   logic             rs2_hit;

   // Next busy vector: applied lowest priority first so later lines override.
   always_comb begin
      busy_nxt = busy;
      if (wr0_en)   busy_nxt[wr0_addr] = 1'b0;
      if (wr1_en)   busy_nxt[wr1_addr] = 1'b0;
      if (issue_en) busy_nxt[issue_rd] = 1'b1;
      if (flush)    busy_nxt = '0;
      busy_nxt[REG_ZERO] = 1'b0;
   end

   // Busy vector register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

   // A completing write-back to the read address masks busy when bypassing.
   always_comb begin
      rs1_hit  = (rs1_addr != ZERO_ADDR) &&
                 ((wr0_en && wr0_addr == rs1_addr) || (wr1_en && wr1_addr == rs1_addr));
      rs2_hit  = (rs2_addr != ZERO_ADDR) &&
                 ((wr0_en && wr0_addr == rs2_addr) || (wr1_en && wr1_addr == rs2_addr));
      rs1_busy = busy[rs1_addr] && !((BYPASS != 0) && rs1_hit);
      rs2_busy = busy[rs2_addr] && !((BYPASS != 0) && rs2_hit);
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: 2 combinational reads, 2 write-backs, busy scoreboard.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int BYPASS = 1
) (
   input logic         clk,
   input logic         rst,
   regfile_mp_if.slave bus
);

   localparam int            AW        = $clog2(NREGS);
   localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

   logic [XLEN-1:0] regs [NREGS];
   logic [XLEN-1:0] rs1_reg;
   logic [XLEN-1:0] rs2_reg;

   // Data array; port 1 is written last so it wins a same-address conflict.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         if (bus.wr0_en && bus.wr0_addr != ZERO_ADDR) regs[bus.wr0_addr] <= bus.wr0_data;
         if (bus.wr1_en && bus.wr1_addr != ZERO_ADDR) regs[bus.wr1_addr] <= bus.wr1_data;
      end
   end

   // Registered-state reads; x0 is hard-wired to zero.
   always_comb begin
      rs1_reg = (bus.rs1_addr == ZERO_ADDR) ? '0 : regs[bus.rs1_addr];
      rs2_reg = (bus.rs2_addr == ZERO_ADDR) ? '0 : regs[bus.rs2_addr];
   end

   generate
      if (BYPASS != 0) begin : g_bypass
         // Forward same-cycle write data, port 1 over port 0; held off while in reset.
         always_comb begin
            bus.rs1_data = rs1_reg;
            bus.rs2_data = rs2_reg;
            if (!rst && bus.rs1_addr != ZERO_ADDR) begin
               if (bus.wr0_en && bus.wr0_addr == bus.rs1_addr) bus.rs1_data = bus.wr0_data;
               if (bus.wr1_en && bus.wr1_addr == bus.rs1_addr) bus.rs1_data = bus.wr1_data;
            end
            if (!rst && bus.rs2_addr != ZERO_ADDR) begin
               if (bus.wr0_en && bus.wr0_addr == bus.rs2_addr) bus.rs2_data = bus.wr0_data;
               if (bus.wr1_en && bus.wr1_addr == bus.rs2_addr) bus.rs2_data = bus.wr1_data;
            end
         end
      end else begin : g_no_bypass
         assign bus.rs1_data = rs1_reg;
         assign bus.rs2_data = rs2_reg;
      end
   endgenerate

   regfile_scoreboard #(
      .NREGS  (NREGS),
      .BYPASS (BYPASS)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .issue_en (bus.issue_en),
      .issue_rd (bus.issue_rd),
      .wr0_en   (bus.wr0_en),
      .wr0_addr (bus.wr0_addr),
      .wr1_en   (bus.wr1_en),
      .wr1_addr (bus.wr1_addr),
      .flush    (bus.flush),
      .rs1_addr (bus.rs1_addr),
      .rs2_addr (bus.rs2_addr),
      .rs1_busy (bus.rs1_busy),
      .rs2_busy (bus.rs2_busy)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench: bypass / no-bypass 32x32 pair plus a 16x64 instance.
module tb_regfile_mp;

   localparam int A_D1 = 0, A_B1 = 1, A_D2 = 2, A_B2 = 3;
   localparam int B_D1 = 4, B_B1 = 5, B_D2 = 6, B_B2 = 7;
   localparam int C_D1 = 8, C_B1 = 9, C_B2 = 10;

   typedef struct {
      string       tag;
      int          sel;
      logic [63:0] exp;
   } exp_t;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   exp_t q[$];

   regfile_mp_if #(.XLEN(32), .AW(5)) bus_a ();
   regfile_mp_if #(.XLEN(32), .AW(5)) bus_b ();
   regfile_mp_if #(.XLEN(64), .AW(4)) bus_c ();

   regfile_mp #(.XLEN(32), .NREGS(32), .BYPASS(1)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
   regfile_mp #(.XLEN(32), .NREGS(32), .BYPASS(0)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
   regfile_mp #(.XLEN(64), .NREGS(16), .BYPASS(1)) u_c (.clk(clk), .rst(rst), .bus(bus_c));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // The no-bypass instance sees exactly the same stimulus as the bypass one.
   always_comb begin
      bus_b.rs1_addr = bus_a.rs1_addr;
      bus_b.rs2_addr = bus_a.rs2_addr;
      bus_b.wr0_en   = bus_a.wr0_en;
      bus_b.wr0_addr = bus_a.wr0_addr;
      bus_b.wr0_data = bus_a.wr0_data;
      bus_b.wr1_en   = bus_a.wr1_en;
      bus_b.wr1_addr = bus_a.wr1_addr;
      bus_b.wr1_data = bus_a.wr1_data;
      bus_b.issue_en = bus_a.issue_en;
      bus_b.issue_rd = bus_a.issue_rd;
      bus_b.flush    = bus_a.flush;
   end

   function automatic logic [63:0] observed(input int sel);
      case (sel)
         A_D1:    return {32'h0, bus_a.rs1_data};
         A_B1:    return {63'h0, bus_a.rs1_busy};
         A_D2:    return {32'h0, bus_a.rs2_data};
         A_B2:    return {63'h0, bus_a.rs2_busy};
         B_D1:    return {32'h0, bus_b.rs1_data};
         B_B1:    return {63'h0, bus_b.rs1_busy};
         B_D2:    return {32'h0, bus_b.rs2_data};
         B_B2:    return {63'h0, bus_b.rs2_busy};
         C_D1:    return bus_c.rs1_data;
         C_B1:    return {63'h0, bus_c.rs1_busy};
         C_B2:    return {63'h0, bus_c.rs2_busy};
         default: return '1;
      endcase
   endfunction

   task automatic exp_push(input string tag, input int sel, input logic [63:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = v;
      q.push_back(e);
   endtask

   task automatic check();
      exp_t        e;
      logic [63:0] obs;
      #1;
      while (q.size() > 0) begin
         e   = q.pop_front();
         obs = observed(e.sel);
         vectors++;
         assert (obs === e.exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic idle_a();
      bus_a.rs1_addr = '0;  bus_a.rs2_addr = '0;
      bus_a.wr0_en   = 1'b0; bus_a.wr0_addr = '0; bus_a.wr0_data = '0;
      bus_a.wr1_en   = 1'b0; bus_a.wr1_addr = '0; bus_a.wr1_data = '0;
      bus_a.issue_en = 1'b0; bus_a.issue_rd = '0; bus_a.flush    = 1'b0;
   endtask

   task automatic idle_c();
      bus_c.rs1_addr = '0;  bus_c.rs2_addr = '0;
      bus_c.wr0_en   = 1'b0; bus_c.wr0_addr = '0; bus_c.wr0_data = '0;
      bus_c.wr1_en   = 1'b0; bus_c.wr1_addr = '0; bus_c.wr1_data = '0;
      bus_c.issue_en = 1'b0; bus_c.issue_rd = '0; bus_c.flush    = 1'b0;
   endtask

   // Advance past one rising edge and return all inputs to idle at the negedge.
   task automatic next();
      @(negedge clk);
      idle_a();
      idle_c();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      idle_a();
      idle_c();
      bus_a.rs1_addr = 5'd5;
      bus_a.rs2_addr = 5'd6;
      #2;
      exp_push("reset_data_a", A_D1, 64'h0);
      exp_push("reset_busy_a", A_B2, 64'h0);
      exp_push("reset_data_b", B_D1, 64'h0);
      check();
      next();
      rst = 1'b0;

      // x0: write and issue to register 0 have no visible effect
      bus_a.wr0_en = 1'b1; bus_a.wr0_addr = 5'd0; bus_a.wr0_data = 32'h1234;
      bus_a.issue_en = 1'b1; bus_a.issue_rd = 5'd0;
      exp_push("x0_data_same", A_D1, 64'h0);
      exp_push("x0_busy_same", A_B1, 64'h0);
      check();
      next();
      exp_push("x0_data_next", A_D1, 64'h0);
      exp_push("x0_busy_next", A_B1, 64'h0);
      exp_push("x0_data_next_b", B_D1, 64'h0);
      check();

      // dual write to x7: port 1 wins
      bus_a.wr0_en = 1'b1; bus_a.wr0_addr = 5'd7; bus_a.wr0_data = 32'h11;
      bus_a.wr1_en = 1'b1; bus_a.wr1_addr = 5'd7; bus_a.wr1_data = 32'h22;
      bus_a.rs1_addr = 5'd7;
      exp_push("dual_bypass_same", A_D1, 64'h22);
      exp_push("dual_nobyp_same", B_D1, 64'h0);
      check();
      next();
      bus_a.rs1_addr = 5'd7;
      exp_push("dual_bypass_next", A_D1, 64'h22);
      exp_push("dual_nobyp_next", B_D1, 64'h22);
      check();

      // bypass on vs off on x3, both read ports
      bus_a.wr0_en = 1'b1; bus_a.wr0_addr = 5'd3; bus_a.wr0_data = 32'hA5A5;
      bus_a.rs1_addr = 5'd3; bus_a.rs2_addr = 5'd3;
      exp_push("x3_bypass_rs1", A_D1, 64'hA5A5);
      exp_push("x3_bypass_rs2", A_D2, 64'hA5A5);
      exp_push("x3_nobyp_rs1", B_D1, 64'h0);
      exp_push("x3_nobyp_rs2", B_D2, 64'h0);
      check();
      next();
      bus_a.rs2_addr = 5'd3;
      exp_push("x3_nobyp_next", B_D2, 64'hA5A5);
      check();

      // scoreboard on x9
      bus_a.issue_en = 1'b1; bus_a.issue_rd = 5'd9; bus_a.rs1_addr = 5'd9;
      exp_push("x9_issue_same_a", A_B1, 64'h0);
      exp_push("x9_issue_same_b", B_B1, 64'h0);
      check();
      next();
      bus_a.rs1_addr = 5'd9;
      exp_push("x9_busy_a", A_B1, 64'h1);
      exp_push("x9_busy_b", B_B1, 64'h1);
      check();
      bus_a.issue_en = 1'b1; bus_a.issue_rd = 5'd9;
      bus_a.wr0_en = 1'b1; bus_a.wr0_addr = 5'd9; bus_a.wr0_data = 32'h99;
      exp_push("x9_iss_wr_mask_a", A_B1, 64'h0);
      exp_push("x9_iss_wr_b", B_B1, 64'h1);
      check();
      next();
      bus_a.rs1_addr = 5'd9;
      exp_push("x9_still_busy_a", A_B1, 64'h1);
      exp_push("x9_still_busy_b", B_B1, 64'h1);
      exp_push("x9_data_a", A_D1, 64'h99);
      exp_push("x9_data_b", B_D1, 64'h99);
      check();
      bus_a.wr1_en = 1'b1; bus_a.wr1_addr = 5'd9; bus_a.wr1_data = 32'h55;
      exp_push("x9_wb_busy_a", A_B1, 64'h0);
      exp_push("x9_wb_data_a", A_D1, 64'h55);
      exp_push("x9_wb_busy_b", B_B1, 64'h1);
      exp_push("x9_wb_data_b", B_D1, 64'h99);
      check();
      next();
      bus_a.rs1_addr = 5'd9;
      exp_push("x9_clear_a", A_B1, 64'h0);
      exp_push("x9_clear_b", B_B1, 64'h0);
      exp_push("x9_final_b", B_D1, 64'h55);
      check();

      // flush beats a same-cycle issue
      bus_a.issue_en = 1'b1; bus_a.issue_rd = 5'd4;
      next();
      bus_a.issue_en = 1'b1; bus_a.issue_rd = 5'd12;
      next();
      bus_a.rs1_addr = 5'd4; bus_a.rs2_addr = 5'd12;
      exp_push("x4_busy", A_B1, 64'h1);
      exp_push("x12_busy", A_B2, 64'h1);
      check();
      bus_a.flush = 1'b1; bus_a.issue_en = 1'b1; bus_a.issue_rd = 5'd4;
      next();
      bus_a.rs1_addr = 5'd4; bus_a.rs2_addr = 5'd12;
      exp_push("flush_x4_a", A_B1, 64'h0);
      exp_push("flush_x12_a", A_B2, 64'h0);
      exp_push("flush_x4_b", B_B1, 64'h0);
      exp_push("flush_x12_b", B_B2, 64'h0);
      check();

      // 16 x 64 instance: wide data, flush priority
      bus_c.wr0_en = 1'b1; bus_c.wr0_addr = 4'd15; bus_c.wr0_data = 64'h0123_4567_89AB_CDEF;
      bus_c.rs1_addr = 4'd15;
      bus_c.issue_en = 1'b1; bus_c.issue_rd = 4'd4;
      exp_push("c_wide_bypass", C_D1, 64'h0123_4567_89AB_CDEF);
      check();
      next();
      bus_c.rs1_addr = 4'd15;
      bus_c.issue_en = 1'b1; bus_c.issue_rd = 4'd12;
      exp_push("c_wide_reg", C_D1, 64'h0123_4567_89AB_CDEF);
      check();
      next();
      bus_c.rs1_addr = 4'd4; bus_c.rs2_addr = 4'd12;
      exp_push("c_x4_busy", C_B1, 64'h1);
      exp_push("c_x12_busy", C_B2, 64'h1);
      check();
      bus_c.flush = 1'b1; bus_c.issue_en = 1'b1; bus_c.issue_rd = 4'd4;
      next();
      bus_c.rs1_addr = 4'd4; bus_c.rs2_addr = 4'd12;
      exp_push("c_flush_x4", C_B1, 64'h0);
      exp_push("c_flush_x12", C_B2, 64'h0);
      check();

      // asynchronous reset mid-cycle clears data and busy immediately
      bus_a.wr0_en = 1'b1; bus_a.wr0_addr = 5'd5; bus_a.wr0_data = 32'hDEADBEEF;
      bus_a.issue_en = 1'b1; bus_a.issue_rd = 5'd6;
      next();
      bus_a.rs1_addr = 5'd5; bus_a.rs2_addr = 5'd6;
      exp_push("pre_rst_data", A_D1, 64'hDEADBEEF);
      exp_push("pre_rst_busy", A_B2, 64'h1);
      check();
      #1;
      rst = 1'b1;
      exp_push("rst_data_a", A_D1, 64'h0);
      exp_push("rst_busy_a", A_B2, 64'h0);
      exp_push("rst_data_b", B_D1, 64'h0);
      exp_push("rst_busy_b", B_B2, 64'h0);
      check();
      next();
      rst = 1'b0;
      bus_a.rs1_addr = 5'd5; bus_a.rs2_addr = 5'd6;
      exp_push("post_rst_data", A_D1, 64'h0);
      exp_push("post_rst_busy", A_B2, 64'h0);
      check();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
